// File: rtl/oam_dma.sv
// oam_dma: sprite DMA engine behind the CPU $4014 register, copies one WRAM page into PPU OAMDATA.
// Latency: rdy drops the cycle after the trigger write; 513 (even) or 514 (odd alignment) halted cycles.
// Backpressure: none accepted; the CPU is stalled via rdy and retriggers are ignored while busy.
//
// Ports:
//   clk, reset          - single clock domain, synchronous active-high reset
//   cpu_addr/data/we    - CPU bus, watched for a write to DMA_REG_ADDR
//   mem_data_in         - WRAM read data, valid one clock after mem_addr
//   rdy                 - CPU suspend, active low
//   dma_active          - bus ownership, steers the WRAM address mux to mem_addr
//   mem_addr            - WRAM read address during a transfer
//   ppu_reg_addr/data_out/we/reg_cs - PPU register write port (cs active low)
module oam_dma #(
  parameter logic [15:0] DMA_REG_ADDR = 16'h4014,
  parameter logic [2:0]  OAM_REG_IDX  = 3'd4,
  parameter int          XFER_LEN     = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_data,
  input  logic        cpu_we,
  input  logic [7:0]  mem_data_in,
  output logic        rdy,
  output logic        dma_active,
  output logic [15:0] mem_addr,
  output logic [2:0]  ppu_reg_addr,
  output logic [7:0]  ppu_data_out,
  output logic        ppu_we,
  output logic        ppu_reg_cs
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HALT  = 3'd1,
    ALIGN = 3'd2,
    READ  = 3'd3,
    WRITE = 3'd4
  } state_t;

  localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

  state_t      state, state_nxt;
  logic [7:0]  page, page_nxt;
  logic [7:0]  count, count_nxt;
  logic        parity;

  logic        rdy_nxt;
  logic        dma_active_nxt;
  logic [15:0] mem_addr_nxt;
  logic [2:0]  ppu_reg_addr_nxt;
  logic        ppu_we_nxt;
  logic        ppu_reg_cs_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      page         <= 8'h00;
      count        <= 8'h00;
      parity       <= 1'b0;
      rdy          <= 1'b1;
      dma_active   <= 1'b0;
      mem_addr     <= 16'h0000;
      ppu_reg_addr <= 3'd0;
      ppu_we       <= 1'b0;
      ppu_reg_cs   <= 1'b1;
    end else begin
      state        <= state_nxt;
      page         <= page_nxt;
      count        <= count_nxt;
      parity       <= ~parity;
      rdy          <= rdy_nxt;
      dma_active   <= dma_active_nxt;
      mem_addr     <= mem_addr_nxt;
      ppu_reg_addr <= ppu_reg_addr_nxt;
      ppu_we       <= ppu_we_nxt;
      ppu_reg_cs   <= ppu_reg_cs_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    page_nxt     = page;
    count_nxt    = count;
    mem_addr_nxt = mem_addr;

    case (state)
      IDLE: begin
        if (cpu_we && (cpu_addr == DMA_REG_ADDR)) begin
          page_nxt  = cpu_data;
          count_nxt = 8'h00;
          state_nxt = HALT;
        end
      end
      // Parity high here means the next cycle would be a CPU get cycle out of
      // phase with the read/write pairing, so burn one cycle to realign.
      HALT:    state_nxt = parity ? ALIGN : READ;
      ALIGN:   state_nxt = READ;
      READ:    state_nxt = WRITE;
      WRITE: begin
        if (count == LAST_IDX) begin
          state_nxt = IDLE;
        end else begin
          count_nxt = count + 8'd1;
          state_nxt = READ;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Outputs are decoded from the next state so the registered copies line
    // up with the state they describe.
    rdy_nxt          = (state_nxt == IDLE);
    dma_active_nxt   = (state_nxt != IDLE);
    ppu_we_nxt       = (state_nxt == WRITE);
    ppu_reg_cs_nxt   = (state_nxt != WRITE);
    ppu_reg_addr_nxt = (state_nxt == WRITE) ? OAM_REG_IDX : 3'd0;
    // mem_addr loads on entry to READ and holds through WRITE so the WRAM
    // read data lines up with the write strobe.
    if (state_nxt == READ) begin
      mem_addr_nxt = {page_nxt, count_nxt};
    end
  end

  // WRAM data flows straight through to the PPU during the write half.
  assign ppu_data_out = (state == WRITE) ? mem_data_in : 8'h00;

endmodule

// File: doc/oam_dma.md
Name: oam_dma

Overview:
- Sprite DMA engine for the NES CPU bus ($4014).
- Sits between the cpu6502/WRAM pair and the PPU register port.
- A CPU write to $4014 latches a source page. The block then halts the CPU by driving rdy low and copies 256 bytes from $XX00-$XXFF to PPU register 4 (OAMDATA, $2004), one byte per read/write cycle pair.
- While active it owns the WRAM address bus and the PPU register chip-select.

Parameters:
- DMA_REG_ADDR, 16'h4014, CPU address that triggers a transfer.
- OAM_REG_IDX, 3'd4, PPU register index written for each byte.
- XFER_LEN, 256, bytes per transfer; must be a power of two, max 256.

Ports:
- clk  input  1  system clock, one CPU cycle per clock
- reset  input  1  synchronous, active-high reset
- cpu_addr  input  16  CPU address bus
- cpu_data  input  8  CPU write data
- cpu_we  input  1  CPU write strobe, active high
- mem_data_in  input  8  WRAM read data, valid one clock after mem_addr is presented
- rdy  output  1  CPU suspend, active low
- dma_active  output  1  high while the block owns the buses; selects mem_addr over cpu_addr
- mem_addr  output  16  WRAM read address during the transfer
- ppu_reg_addr  output  3  PPU register index
- ppu_data_out  output  8  data to the PPU register
- ppu_we  output  1  PPU register write strobe, active high
- ppu_reg_cs  output  1  PPU register chip select, active low

Behaviour:
- Clock and reset: one clock domain, clk. Reset is synchronous and active-high and beats every other input on the same edge.
- Reset values: rdy=1, dma_active=0, mem_addr=0, ppu_reg_addr=0, ppu_data_out=0, ppu_we=0, ppu_reg_cs=1, state=IDLE, page=0, count=0, parity=0.
- Parity: a flop that toggles on every clock edge, cleared by reset. It models the CPU get/put cycle.
- Trigger: in IDLE, when cpu_we=1 and cpu_addr=DMA_REG_ADDR:
  - page <= cpu_data, count <= 0, next state HALT.
  - Writes to any other address are ignored.
  - Triggers outside IDLE are ignored.
- States:
  - IDLE: rdy=1, dma_active=0, ppu_we=0, ppu_reg_cs=1.
  - HALT: exactly 1 cycle; rdy=0, dma_active=1. Next state is ALIGN if parity=1 in this cycle, otherwise READ.
  - ALIGN: exactly 1 cycle; rdy=0, no bus activity. Next state READ.
  - READ: mem_addr={page,count}, rdy=0, ppu_we=0, ppu_reg_cs=1. Next state WRITE.
  - WRITE:
    - ppu_reg_addr=OAM_REG_IDX, ppu_data_out=mem_data_in (combinational pass-through), ppu_we=1, ppu_reg_cs=0, rdy=0.
    - mem_addr holds its READ value.
    - If count=XFER_LEN-1, next state IDLE. Otherwise count <= count+1 and next state READ.
- Counter: 8 bits, wraps naturally; the page byte never changes during a transfer.
- Latency:
  - rdy falls on the first clock after the triggering write.
  - rdy is low for 513 cycles (even alignment) or 514 cycles (odd alignment).
  - rdy returns high in the cycle after the final WRITE.
- Outputs from the state are registered. ppu_data_out is the only combinational path, mem_data_in -> ppu_data_out.
- Reset mid-transfer: back to IDLE on the next edge with all outputs at their reset values. The partially copied bytes remain in OAM.
- Page $40 or above is copied as-is (no special-casing of the source page).
- A new trigger may be accepted on the same edge that IDLE is re-entered plus one, i.e. in the first IDLE cycle.

Test Plan:
- Reset, then write $02 to $4014 with parity=0 at HALT -> rdy low for 513 cycles; mem_addr steps $0200..$02FF; 256 ppu_we pulses with ppu_reg_addr=4; byte n on ppu_data_out equals WRAM[$0200+n].
- Same trigger with parity=1 at HALT -> one ALIGN cycle with no bus activity; rdy low for 514 cycles; first READ one cycle later than in the first scenario.
- Write $07 to $4015 and read $4014 (cpu_we=0) -> no state change; rdy stays 1, ppu_reg_cs stays 1.
- Assert reset at the 100th WRITE of a transfer -> next cycle rdy=1, dma_active=0, ppu_reg_cs=1. A following trigger with $03 restarts from $0300.
- Write $4014 again while a transfer is in progress -> ignored; the transfer completes with the original page. Back-to-back triggers with $05 then $06 produce two full transfers.
- Reset asserted on the same edge as a $4014 write -> block stays IDLE, page=0.
